// File: rtl/alu_pkg.sv
// Shared ALU op codes, arbiter state encoding and op legality check.
package alu_pkg;

    localparam int unsigned OP_W = 4;

    localparam logic [OP_W-1:0] ALU_ADD = 4'b0000;
    localparam logic [OP_W-1:0] ALU_SUB = 4'b0001;
    localparam logic [OP_W-1:0] ALU_AND = 4'b0010;
    localparam logic [OP_W-1:0] ALU_OR  = 4'b0011;
    localparam logic [OP_W-1:0] ALU_NOT = 4'b0100;
    localparam logic [OP_W-1:0] ALU_SLT = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    function automatic logic is_legal_op(input logic [OP_W-1:0] op);
        case (op)
            ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOT, ALU_SLT: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response channels of the two ALU requesters plus arbiter status.
interface alu_arbiter_if #(parameter int unsigned DATA_W = 32);

    logic              r0_valid;
    logic              r0_ready;
    logic [3:0]        r0_op;
    logic [DATA_W-1:0] r0_a;
    logic [DATA_W-1:0] r0_b;
    logic              r0_rvalid;
    logic              r0_rready;
    logic [DATA_W-1:0] r0_result;
    logic              r0_zero;
    logic              r0_err;

    logic              r1_valid;
    logic              r1_ready;
    logic [3:0]        r1_op;
    logic [DATA_W-1:0] r1_a;
    logic [DATA_W-1:0] r1_b;
    logic              r1_rvalid;
    logic              r1_rready;
    logic [DATA_W-1:0] r1_result;
    logic              r1_zero;
    logic              r1_err;

    logic              busy;
    logic              grant_id;

    modport master (
        output r0_valid, r0_op, r0_a, r0_b, r0_rready,
        output r1_valid, r1_op, r1_a, r1_b, r1_rready,
        input  r0_ready, r0_rvalid, r0_result, r0_zero, r0_err,
        input  r1_ready, r1_rvalid, r1_result, r1_zero, r1_err,
        input  busy, grant_id
    );

    modport slave (
        input  r0_valid, r0_op, r0_a, r0_b, r0_rready,
        input  r1_valid, r1_op, r1_a, r1_b, r1_rready,
        output r0_ready, r0_rvalid, r0_result, r0_zero, r0_err,
        output r1_ready, r1_rvalid, r1_result, r1_zero, r1_err,
        output busy, grant_id
    );

endinterface

// File: rtl/alu_arbiter_alu.sv
// Combinational 32-bit ALU: ADD, SUB, AND, OR, NOT, signed SLT.
module alu_arbiter_alu
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [OP_W-1:0]   ALUControl,
    output logic [DATA_W-1:0] ALUOut,
    output logic              Zero
);

    always_comb begin
        ALUOut = '0;
        case (ALUControl)
            ALU_ADD: ALUOut = A + B;
            ALU_SUB: ALUOut = A - B;
            ALU_AND: ALUOut = A & B;
            ALU_OR:  ALUOut = A | B;
            ALU_NOT: ALUOut = ~A;
            ALU_SLT: ALUOut = DATA_W'($signed(A) < $signed(B));
            default: ALUOut = '0;
        endcase
    end

    assign Zero = (ALUOut == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between execute (r0) and branch/address (r1)
// requesters; fixed IDLE -> EXEC -> RESP sequence with held responses.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned RESET_PRIO = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_arbiter_if.slave  bus
);

    state_t            r_state;
    logic              r_prio;
    logic              r_owner;
    logic              r_busy;
    logic [OP_W-1:0]   r_op;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [1:0]        r_rvalid;
    logic [DATA_W-1:0] r_result0;
    logic [DATA_W-1:0] r_result1;
    logic [1:0]        r_zero;
    logic [1:0]        r_err;

    logic              w_grant0;
    logic              w_grant1;
    logic              w_owner_rready;
    logic              w_legal;
    logic [DATA_W-1:0] w_alu_out;
    logic              w_alu_zero;
    logic [DATA_W-1:0] w_res_result;
    logic              w_res_zero;

    // Single grant only in IDLE; the priority pointer breaks ties.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (r_state == ST_IDLE) begin
            w_grant0 = bus.r0_valid && (!bus.r1_valid || (r_prio == 1'b0));
            w_grant1 = bus.r1_valid && (!bus.r0_valid || (r_prio == 1'b1));
        end
    end

    assign w_owner_rready = r_owner ? bus.r1_rready : bus.r0_rready;

    alu_arbiter_alu #(.DATA_W(DATA_W)) u_alu (
        .A          (r_a),
        .B          (r_b),
        .ALUControl (r_op),
        .ALUOut     (w_alu_out),
        .Zero       (w_alu_zero)
    );

    // Illegal ops override the ALU: result 0, zero 1, err 1.
    assign w_legal      = is_legal_op(r_op);
    assign w_res_result = w_legal ? w_alu_out : '0;
    assign w_res_zero   = w_legal ? w_alu_zero : 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_prio    <= 1'(RESET_PRIO);
            r_owner   <= 1'(RESET_PRIO);
            r_busy    <= 1'b0;
            r_op      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_rvalid  <= '0;
            r_result0 <= '0;
            r_result1 <= '0;
            r_zero    <= '0;
            r_err     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant0 || w_grant1) begin
                        r_state <= ST_EXEC;
                        r_busy  <= 1'b1;
                        r_owner <= w_grant1;
                        r_prio  <= ~w_grant1;
                        r_op    <= w_grant1 ? bus.r1_op : bus.r0_op;
                        r_a     <= w_grant1 ? bus.r1_a  : bus.r0_a;
                        r_b     <= w_grant1 ? bus.r1_b  : bus.r0_b;
                    end
                end
                ST_EXEC: begin
                    r_state <= ST_RESP;
                    if (r_owner) begin
                        r_result1   <= w_res_result;
                        r_zero[1]   <= w_res_zero;
                        r_err[1]    <= ~w_legal;
                        r_rvalid[1] <= 1'b1;
                    end else begin
                        r_result0   <= w_res_result;
                        r_zero[0]   <= w_res_zero;
                        r_err[0]    <= ~w_legal;
                        r_rvalid[0] <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (w_owner_rready) begin
                        r_state  <= ST_IDLE;
                        r_busy   <= 1'b0;
                        r_rvalid <= '0;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_busy   <= 1'b0;
                    r_rvalid <= '0;
                end
            endcase
        end
    end

    assign bus.r0_ready  = w_grant0;
    assign bus.r1_ready  = w_grant1;
    assign bus.r0_rvalid = r_rvalid[0];
    assign bus.r1_rvalid = r_rvalid[1];
    assign bus.r0_result = r_result0;
    assign bus.r1_result = r_result1;
    assign bus.r0_zero   = r_zero[0];
    assign bus.r1_zero   = r_zero[1];
    assign bus.r0_err    = r_err[0];
    assign bus.r1_err    = r_err[1];
    assign bus.busy      = r_busy;
    assign bus.grant_id  = r_owner;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed requests push expected responses,
// a monitor pops and compares on every completed response handshake.
module tb_alu_arbiter;
    import alu_pkg::*;

    typedef struct {
        int          id;
        logic [31:0] res;
        logic        z;
        logic        e;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid [2];
    logic        rready [2];
    logic [3:0]  op [2];
    logic [31:0] a [2];
    logic [31:0] b [2];

    exp_t sb[$];
    int   acc_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    alu_arbiter_if #(.DATA_W(32)) bus ();

    assign bus.r0_valid  = valid[0];
    assign bus.r0_op     = op[0];
    assign bus.r0_a      = a[0];
    assign bus.r0_b      = b[0];
    assign bus.r0_rready = rready[0];
    assign bus.r1_valid  = valid[1];
    assign bus.r1_op     = op[1];
    assign bus.r1_a      = a[1];
    assign bus.r1_b      = b[1];
    assign bus.r1_rready = rready[1];

    alu_arbiter #(.DATA_W(32), .RESET_PRIO(0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic rdy(input int id);
        return (id == 1) ? bus.r1_ready : bus.r0_ready;
    endfunction

    function automatic exp_t mk(input int id, input logic [31:0] res, input logic z, input logic e);
        exp_t x;
        x.id = id; x.res = res; x.z = z; x.e = e;
        return x;
    endfunction

    // Hold valid with fixed fields for n accepts; returns cycles waited before the first accept.
    task automatic send(input int id, input logic [3:0] o, input logic [31:0] va,
                        input logic [31:0] vb, input int n, output int waited);
        int t;
        waited = 0;
        op[id] = o; a[id] = va; b[id] = vb; valid[id] = 1'b1;
        #1;
        for (int k = 0; k < n; k++) begin
            t = 0;
            while (!rdy(id) && t <= 100) begin
                @(negedge clk); #1;
                t++;
            end
            if (t > 100) begin
                total++; bad++;
                $display("FAIL accept_timeout_r%0d actual=no_ready required=ready", id);
                break;
            end
            if (k == 0) waited = t;
            @(posedge clk);
            acc_q.push_back(cyc);
            @(negedge clk); #1;
        end
        valid[id] = 1'b0;
    endtask

    // Monitor: compare each response at the point it is handed over.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk); #3;
            if (rst_n) begin
                if (bus.r0_rvalid || bus.r1_rvalid)
                    chk("single_owner_rvalid", 32'(bus.r0_rvalid && bus.r1_rvalid), 32'd0);
                for (int id = 0; id < 2; id++) begin
                    logic rv;
                    logic [31:0] rs;
                    logic rz, re;
                    rv = (id == 1) ? bus.r1_rvalid : bus.r0_rvalid;
                    rs = (id == 1) ? bus.r1_result : bus.r0_result;
                    rz = (id == 1) ? bus.r1_zero   : bus.r0_zero;
                    re = (id == 1) ? bus.r1_err    : bus.r0_err;
                    if (rv && rready[id]) begin
                        if (sb.size() == 0) begin
                            total++; bad++;
                            $display("FAIL unexpected_resp_r%0d actual=%h required=none", id, rs);
                        end else begin
                            e = sb.pop_front();
                            chk("resp_owner",  32'(id), 32'(e.id));
                            chk("resp_result", rs, e.res);
                            chk("resp_zero",   32'(rz), 32'(e.z));
                            chk("resp_err",    32'(re), 32'(e.e));
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            valid[i] = 1'b0; rready[i] = 1'b1; op[i] = '0; a[i] = '0; b[i] = '0;
        end
        repeat (3) @(negedge clk);
        #1;
        chk("rst_r0_rvalid", 32'(bus.r0_rvalid), 32'd0);
        chk("rst_r1_rvalid", 32'(bus.r1_rvalid), 32'd0);
        chk("rst_r0_result", bus.r0_result, 32'd0);
        chk("rst_r1_result", bus.r1_result, 32'd0);
        chk("rst_zero_err", {28'd0, bus.r0_zero, bus.r0_err, bus.r1_zero, bus.r1_err}, 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_grant_id", 32'(bus.grant_id), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // r0 ADD 1+1: immediate grant, response two samples after accept
        @(negedge clk);
        sb.push_back(mk(0, 32'h2, 1'b0, 1'b0));
        send(0, ALU_ADD, 32'd1, 32'd1, 1, w);
        chk("add_first_cycle_grant", 32'(w), 32'd0);
        chk("add_exec_rvalid", 32'(bus.r0_rvalid), 32'd0);
        chk("add_exec_busy", 32'(bus.busy), 32'd1);
        @(negedge clk); #1;
        chk("add_resp_rvalid", 32'(bus.r0_rvalid), 32'd1);
        chk("add_resp_result", bus.r0_result, 32'h2);
        @(negedge clk); #1;
        chk("add_done_rvalid", 32'(bus.r0_rvalid), 32'd0);
        chk("add_done_busy", 32'(bus.busy), 32'd0);

        // r1 SUB 1-1 -> 0, zero
        @(negedge clk);
        sb.push_back(mk(1, 32'h0, 1'b1, 1'b0));
        send(1, ALU_SUB, 32'd1, 32'd1, 1, w);
        chk("sub_grant_id", 32'(bus.grant_id), 32'd1);
        @(negedge clk); #1;
        chk("sub_r1_rvalid", 32'(bus.r1_rvalid), 32'd1);
        chk("sub_r0_rvalid", 32'(bus.r0_rvalid), 32'd0);
        repeat (2) @(negedge clk);

        // both valid continuously: r0, r1, r0, r1 at 3-cycle spacing
        acc_q.delete();
        sb.push_back(mk(0, 32'h1, 1'b0, 1'b0));
        sb.push_back(mk(1, 32'h1, 1'b0, 1'b0));
        sb.push_back(mk(0, 32'h1, 1'b0, 1'b0));
        sb.push_back(mk(1, 32'h1, 1'b0, 1'b0));
        fork
            begin int w0; send(0, ALU_AND, 32'd1, 32'd1, 2, w0); end
            begin int w1; send(1, ALU_OR,  32'd1, 32'd1, 2, w1); end
        join
        repeat (3) @(negedge clk);
        chk("rr_accept_count", 32'(acc_q.size()), 32'd4);
        if (acc_q.size() == 4)
            for (int i = 1; i < 4; i++)
                chk("rr_accept_spacing", 32'(acc_q[i] - acc_q[i-1]), 32'd3);

        // r0 NOT held for 5 cycles while r1 waits
        rready[0] = 1'b0;
        @(negedge clk);
        sb.push_back(mk(0, 32'hFFFF_FFFE, 1'b0, 1'b0));
        send(0, ALU_NOT, 32'd1, 32'd0, 1, w);
        fork
            begin
                int w1;
                @(negedge clk);
                sb.push_back(mk(1, 32'd5, 1'b0, 1'b0));
                send(1, ALU_ADD, 32'd2, 32'd3, 1, w1);
            end
            begin
                repeat (5) begin
                    @(negedge clk); #1;
                    chk("hold_rvalid", 32'(bus.r0_rvalid), 32'd1);
                    chk("hold_result", bus.r0_result, 32'hFFFF_FFFE);
                    chk("hold_busy", 32'(bus.busy), 32'd1);
                    chk("hold_r1_ready", 32'(bus.r1_ready), 32'd0);
                end
                @(negedge clk);
                rready[0] = 1'b1;
                @(negedge clk); #1;
                chk("release_busy", 32'(bus.busy), 32'd0);
                chk("release_rvalid", 32'(bus.r0_rvalid), 32'd0);
                chk("release_r1_ready", 32'(bus.r1_ready), 32'd1);
            end
        join
        repeat (3) @(negedge clk);

        // SLT signed: 1<1 -> 0, -1<1 -> 1
        sb.push_back(mk(0, 32'h0, 1'b1, 1'b0));
        send(0, ALU_SLT, 32'd1, 32'd1, 1, w);
        repeat (2) @(negedge clk);
        sb.push_back(mk(0, 32'h1, 1'b0, 1'b0));
        send(0, ALU_SLT, 32'hFFFF_FFFF, 32'd1, 1, w);
        repeat (2) @(negedge clk);

        // illegal op on r1
        sb.push_back(mk(1, 32'h0, 1'b1, 1'b1));
        send(1, 4'b0101, 32'd5, 32'd7, 1, w);
        repeat (2) @(negedge clk);

        // reset during EXEC discards the transaction
        send(1, ALU_ADD, 32'd3, 32'd4, 1, w);
        chk("pre_rst_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_grant_id", 32'(bus.grant_id), 32'd0);
        chk("midrst_r0_result", bus.r0_result, 32'd0);
        chk("midrst_r1_flags", {30'd0, bus.r1_zero, bus.r1_err}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk); #1;
            chk("post_rst_no_rvalid", {30'd0, bus.r0_rvalid, bus.r1_rvalid}, 32'd0);
        end

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
